// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: default bus widths and byte-enable encoding.
package cpu_pkg;
  localparam int AWIDTH_DEF = 32;
  localparam int DWIDTH_DEF = 32;
  localparam int BE_W       = 4;
  localparam logic [BE_W-1:0] WREN_NONE = 4'b0000;
endpackage

// File: rtl/mux_2to1.sv
// Generic two-input multiplexer; sel=1 selects b.
module mux_2to1 #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU load/store path (priority) and one DMA requester.
// Optional anti-starvation forced grant is built when DMEM_ARB_FAIRNESS_EN is defined.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  input  logic [BE_W-1:0]   cpu_wren,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic [AWIDTH-1:0] dma_addr,
  input  logic [DWIDTH-1:0] dma_wdata,
  input  logic [BE_W-1:0]   dma_wren,
  output logic              dma_rvalid,
  output logic [DWIDTH-1:0] dma_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_wren,
  input  logic [DWIDTH-1:0] mem_rdata
);

  // DMA handshake: a transfer happens at the rising edge where dma_valid && dma_ready;
  // the requester holds valid and its fields stable until then. Reads answer one cycle
  // later with a single-cycle dma_rvalid pulse; writes produce no response.
  logic dma_gnt;
  logic dma_rd;

  assign dma_rd    = (dma_wren == WREN_NONE);
  assign dma_ready = dma_gnt;
  assign cpu_rdata = mem_rdata;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic          wait_sat;

  assign wait_sat  = (wait_cnt == WAIT_MAX);
  assign dma_gnt   = dma_valid && (!cpu_req || wait_sat);
  assign cpu_stall = dma_gnt && cpu_req;

  // Counts refused cycles of a pending request; any grant or a dropped request restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!dma_valid || dma_gnt) begin
      wait_cnt <= '0;
    end else if (!wait_sat) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  assign dma_gnt   = dma_valid && !cpu_req;
  assign cpu_stall = 1'b0;
`endif

  // While the DMA owns the port the CPU fields, including its write enables, are not routed.
  mux_2to1 #(.W(AWIDTH)) u_mux_addr (
    .a   (cpu_addr),
    .b   (dma_addr),
    .sel (dma_gnt),
    .y   (mem_addr)
  );

  mux_2to1 #(.W(DWIDTH)) u_mux_wdata (
    .a   (cpu_wdata),
    .b   (dma_wdata),
    .sel (dma_gnt),
    .y   (mem_wdata)
  );

  mux_2to1 #(.W(BE_W)) u_mux_wren (
    .a   (cpu_wren),
    .b   (dma_wren),
    .sel (dma_gnt),
    .y   (mem_wren)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_gnt && dma_rd;
      if (dma_gnt && dma_rd) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read memory model and
// a read-response scoreboard.
module tb_dmem_arbiter;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wren;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_valid;
  logic        dma_ready;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wren;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wren;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  dmem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wren   (cpu_wren),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_valid  (dma_valid),
    .dma_ready  (dma_ready),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_wren   (dma_wren),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren),
    .mem_rdata  (mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: 16 words, combinational read, byte-enabled write at the edge
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[8]  <= 32'h12345678;
      mem[12] <= 32'h11223344;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wren[b]) mem[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wren);
    cpu_req   = req;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wren  = wren;
  endtask

  task automatic set_dma(input logic valid, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wren);
    dma_valid = valid;
    dma_addr  = addr;
    dma_wdata = wdata;
    dma_wren  = wren;
  endtask

  // monitor: every read response pops one expected value
  always @(negedge clk) begin
    if (dma_rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("dma_rdata", dma_rdata, e);
      end
    end
  end

  initial begin
    rst = 1'b0;
    set_cpu(1'b0, 32'h0, 32'h0, WREN_NONE);
    set_dma(1'b0, 32'h0, 32'h0, WREN_NONE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rvalid", {31'd0, dma_rvalid}, 32'd0);
    check("reset_rdata", dma_rdata, 32'h0);
    check("reset_stall", {31'd0, cpu_stall}, 32'd0);
    next_cycle();
    rst = 1'b1;

    // CPU-only store
    next_cycle();
    set_cpu(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("cpu_mem_addr", mem_addr, 32'h10);
    check("cpu_mem_wren", {28'd0, mem_wren}, 32'hF);
    check("cpu_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("cpu_stall_idle", {31'd0, cpu_stall}, 32'd0);
    check("cpu_dma_ready", {31'd0, dma_ready}, 32'd0);

    // uncontended DMA read
    next_cycle();
    set_cpu(1'b0, 32'h0, 32'h0, WREN_NONE);
    set_dma(1'b1, 32'h20, 32'h0, WREN_NONE);
    @(negedge clk);
    check("idle_dma_ready", {31'd0, dma_ready}, 32'd1);
    check("idle_mem_addr", mem_addr, 32'h20);
    check("idle_stall", {31'd0, cpu_stall}, 32'd0);
    exp_q.push_back(32'h12345678);
    next_cycle();
    set_dma(1'b0, 32'h0, 32'h0, WREN_NONE);
    next_cycle();

    // contention: CPU stores continuously while the DMA requests a read
    set_cpu(1'b1, 32'h08, 32'hCAFEF00D, 4'hF);
    set_dma(1'b1, 32'h20, 32'h0, WREN_NONE);
`ifdef DMEM_ARB_FAIRNESS_EN
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("cont_ready_c%0d", i + 1), {31'd0, dma_ready}, (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("cont_stall_c%0d", i + 1), {31'd0, cpu_stall}, (i == 4) ? 32'd1 : 32'd0);
      if (i == 4) begin
        check("cont_wren_masked", {28'd0, mem_wren}, 32'h0);
        check("cont_mem_addr", mem_addr, 32'h20);
        exp_q.push_back(32'h12345678);
      end
      next_cycle();
    end
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("starve_ready_c%0d", i + 1), {31'd0, dma_ready}, 32'd0);
      check($sformatf("starve_stall_c%0d", i + 1), {31'd0, cpu_stall}, 32'd0);
      next_cycle();
    end
`endif
    set_cpu(1'b0, 32'h0, 32'h0, WREN_NONE);
    set_dma(1'b0, 32'h0, 32'h0, WREN_NONE);
    next_cycle();

    // reset right after an accepted read discards the response
    set_dma(1'b1, 32'h20, 32'h0, WREN_NONE);
    @(negedge clk);
    check("rstmid_ready", {31'd0, dma_ready}, 32'd1);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rstmid_rvalid", {31'd0, dma_rvalid}, 32'd0);
    check("rstmid_rdata", dma_rdata, 32'h0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rstpost_ready", {31'd0, dma_ready}, 32'd1);
    exp_q.push_back(32'h12345678);
    next_cycle();
    set_dma(1'b0, 32'h0, 32'h0, WREN_NONE);
    next_cycle();

    // DMA partial write, then read it back
    set_dma(1'b1, 32'h30, 32'hA5A5A5A5, 4'h3);
    @(negedge clk);
    check("wr_ready", {31'd0, dma_ready}, 32'd1);
    check("wr_mem_wren", {28'd0, mem_wren}, 32'h3);
    check("wr_mem_addr", mem_addr, 32'h30);
    check("wr_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    next_cycle();
    set_dma(1'b0, 32'h0, 32'h0, WREN_NONE);
    @(negedge clk);
    check("wr_no_rvalid", {31'd0, dma_rvalid}, 32'd0);
    next_cycle();
    set_dma(1'b1, 32'h30, 32'h0, WREN_NONE);
    @(negedge clk);
    check("rb_ready", {31'd0, dma_ready}, 32'd1);
    exp_q.push_back(32'h1122A5A5);
    next_cycle();
    set_dma(1'b0, 32'h0, 32'h0, WREN_NONE);
    repeat (3) next_cycle();

    // final report
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
